uart_baud_gen_frac: RTL and testbench
=====================================

Name: uart_baud_gen_frac

Overview:
- Programmable fractional baud-rate generator for the UART TX/RX datapaths.
- Replaces the fixed four-rate divider with a run-time integer + fractional divisor.
- Produces an oversample strobe, a bit strobe, a mid-bit sample strobe and a square-wave baud clock.
- Supports glitch-free divisor updates at bit boundaries and phase re-alignment for RX start-bit detection.

Parameters:
- DIV_W, 16, width of the integer divisor (clock cycles per oversample tick).
- FRAC_W, 4, width of the fractional divisor; fraction = div_frac / 2^FRAC_W.
- OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4.
- RST_INT, 27, integer divisor active after reset.
- RST_FRAC, 2, fractional divisor active after reset.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  counting enable; low freezes all counters
- div_int  input  DIV_W  requested integer divisor
- div_frac  input  FRAC_W  requested fractional divisor
- div_load  input  1  one-cycle strobe; captures div_int/div_frac into the shadow register
- sync_clear  input  1  synchronous phase restart (RX start-bit alignment)
- tick_os  output  1  one-cycle oversample strobe
- tick_mid  output  1  one-cycle strobe at mid-bit
- tick_bit  output  1  one-cycle strobe at bit boundary
- baud_clk  output  1  square wave, toggles on every tick_bit
- load_pending  output  1  shadow divisor captured but not yet active

Behaviour:
- Reset (async, reset=0):
  - cnt, frac_acc and os_cnt = 0.
  - Active divisor = RST_INT / RST_FRAC; shadow = same values.
  - All outputs = 0.
- Clamp: any integer divisor < 2, whether active or loaded, is treated as 2.
- Period generation:
  - cnt increments on each enabled edge.
  - Period length P = active_int + c, where c = carry-out of (frac_acc + active_frac) at FRAC_W bits.
  - On the edge where cnt == P-1:
    - cnt <= 0.
    - frac_acc <= (frac_acc + active_frac) mod 2^FRAC_W.
    - tick_os is high for the following cycle.
  - Average period = active_int + active_frac/2^FRAC_W clocks.
  - First tick_os comes exactly P enabled cycles after reset release.
- os_cnt advances 0..OVERSAMPLE-1 on each tick_os and wraps to 0.
  - tick_bit is asserted together with the tick_os that wraps os_cnt from OVERSAMPLE-1 to 0.
  - tick_mid is asserted together with the tick_os that moves os_cnt from OVERSAMPLE/2-1 to OVERSAMPLE/2.
- baud_clk toggles in the cycle tick_bit is high, so its period = 2 bit times.
- All strobes are registered, last exactly one cycle, and are never asserted in consecutive cycles.
- enable=0:
  - cnt, frac_acc and os_cnt hold.
  - Strobes are 0; baud_clk holds.
  - A pending divisor is applied immediately.
- div_load:
  - Captures inputs into the shadow register; load_pending <= 1.
  - The shadow is applied (active <= shadow, load_pending <= 0) on the cycle tick_bit fires, so the new period starts with the next bit.
  - A second div_load while pending overwrites the shadow; only the last value is applied.
- sync_clear (highest priority over counting and loading):
  - Next edge: cnt, frac_acc and os_cnt = 0; strobes = 0; baud_clk = 0.
  - Any pending shadow is applied and load_pending = 0.
  - div_load and sync_clear in the same cycle: the new inputs become active directly.
  - Counting resumes on the following edge.
- Reset mid-operation: asserting reset aborts immediately, with no partial strobe.
  - After release, behaviour is identical to power-up and the RST_* divisor is active; any earlier load is lost.
- Width rules:
  - cnt is DIV_W+1 bits wide, so it holds 2^DIV_W-1+1 without overflow.
  - frac_acc is FRAC_W bits wide and wraps naturally.

Test Plan:
- div_int=4, div_frac=0, enable=1 -> tick_os every 4 cycles; tick_bit every 64 cycles; tick_mid 32 cycles after each tick_bit; baud_clk period 128.
- div_int=4, div_frac=8 (0.5) -> tick_os intervals 4,5,4,5...; over 16 ticks the total is exactly 72 cycles.
- div_int=0 and div_int=1 loaded -> both behave as 2: tick_os every 2 cycles, never every cycle.
- div_load(int=10) mid-bit while running int=4 -> load_pending=1 until the next tick_bit; ticks after that tick_bit are spaced 10; two loads before the boundary -> only the second value is applied.
- sync_clear at os_cnt=7 -> no strobes in the next cycle; baud_clk=0; next tick_os P cycles later; tick_mid after 8 ticks; tick_bit after 16 ticks.
- enable low for 20 cycles mid-period, then high -> remaining period completes with no lost or extra ticks; reset asserted mid-bit -> all outputs 0 immediately, first tick_os after release = 27 cycles (RST_INT=27, frac_acc=0+2 gives no carry).

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_frac
//   Fractional baud-rate generator for the UART TX/RX datapaths.
//   The oversample period is a run-time integer + fractional divisor:
//   each period lasts active_int (+1 when the fractional accumulator carries),
//   so the long-run average is active_int + active_frac / 2^FRAC_W clocks.
//   OVERSAMPLE oversample ticks make one bit. Strobes are derived from these.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-low reset
//   enable       counting enable; low freezes all counters, strobes stay low
//   div_int      requested integer divisor (values < 2 behave as 2)
//   div_frac     requested fractional divisor (fraction = div_frac / 2^FRAC_W)
//   div_load     one-cycle strobe: capture div_int/div_frac into the shadow
//   sync_clear   synchronous phase restart (RX start-bit alignment)
//   tick_os      one-cycle oversample strobe
//   tick_mid     one-cycle strobe at mid-bit
//   tick_bit     one-cycle strobe at bit boundary
//   baud_clk     square wave, toggles together with tick_bit
//   load_pending shadow divisor captured but not yet active
// ---------------------------------------------------------------------------
module uart_baud_gen_frac #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RST_INT    = 27,
  parameter int RST_FRAC   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              sync_clear,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic              baud_clk,
  output logic              load_pending
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  RST_INT_V  = DIV_W'(RST_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC_V = FRAC_W'(RST_FRAC);
  localparam logic [OS_W-1:0]   OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);

  // One extra bit so a period of 2^DIV_W-1 plus a carry still fits.
  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;

  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic              load_pending_q, load_pending_d;

  logic              tick_os_q, tick_os_d;
  logic              tick_mid_q, tick_mid_d;
  logic              tick_bit_q, tick_bit_d;
  logic              baud_clk_q, baud_clk_d;

  logic [DIV_W-1:0]  eff_int;
  logic [FRAC_W:0]   frac_sum;
  logic              carry;
  logic [DIV_W:0]    period_m1;
  logic              period_end;
  logic              os_last;
  logic              os_half;
  logic              bit_end;

  // Period arithmetic. The clamp is applied at use so a small RST_INT
  // parameter is covered as well as loaded values.
  always_comb begin
    eff_int    = (act_int_q < DIV_W'(2)) ? DIV_W'(2) : act_int_q;
    frac_sum   = {1'b0, frac_acc_q} + {1'b0, act_frac_q};
    carry      = frac_sum[FRAC_W];
    period_m1  = {1'b0, eff_int} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
    period_end = enable && (cnt_q == period_m1);
    os_last    = (os_cnt_q == OS_LAST);
    os_half    = (os_cnt_q == OS_HALF_M1);
    bit_end    = period_end && os_last;
  end

  always_comb begin
    cnt_d          = cnt_q;
    frac_acc_d     = frac_acc_q;
    os_cnt_d       = os_cnt_q;
    act_int_d      = act_int_q;
    act_frac_d     = act_frac_q;
    shd_int_d      = shd_int_q;
    shd_frac_d     = shd_frac_q;
    load_pending_d = load_pending_q;
    tick_os_d      = 1'b0;
    tick_mid_d     = 1'b0;
    tick_bit_d     = 1'b0;
    baud_clk_d     = baud_clk_q;

    if (sync_clear) begin
      // Phase restart: everything back to zero; a divisor presented in the
      // same cycle bypasses the shadow and becomes active straight away.
      cnt_d          = '0;
      frac_acc_d     = '0;
      os_cnt_d       = '0;
      baud_clk_d     = 1'b0;
      load_pending_d = 1'b0;
      if (div_load) begin
        act_int_d  = div_int;
        act_frac_d = div_frac;
        shd_int_d  = div_int;
        shd_frac_d = div_frac;
      end else if (load_pending_q) begin
        act_int_d  = shd_int_q;
        act_frac_d = shd_frac_q;
      end
    end else begin
      if (enable) begin
        if (period_end) begin
          cnt_d      = '0;
          frac_acc_d = frac_sum[FRAC_W-1:0];
          os_cnt_d   = os_cnt_q + OS_W'(1);
          tick_os_d  = 1'b1;
          tick_mid_d = os_half;
          tick_bit_d = os_last;
          if (os_last) baud_clk_d = ~baud_clk_q;
        end else begin
          cnt_d = cnt_q + (DIV_W+1)'(1);
        end
      end

      // Swap divisors only at a bit boundary, so the new rate starts with a
      // whole bit. While frozen there is no phase to protect: apply at once.
      if (load_pending_q && (!enable || bit_end)) begin
        act_int_d      = shd_int_q;
        act_frac_d     = shd_frac_q;
        load_pending_d = 1'b0;
      end

      // A fresh capture wins over the apply above: it stays pending.
      if (div_load) begin
        shd_int_d      = div_int;
        shd_frac_d     = div_frac;
        load_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      frac_acc_q     <= '0;
      os_cnt_q       <= '0;
      act_int_q      <= RST_INT_V;
      act_frac_q     <= RST_FRAC_V;
      shd_int_q      <= RST_INT_V;
      shd_frac_q     <= RST_FRAC_V;
      load_pending_q <= 1'b0;
      tick_os_q      <= 1'b0;
      tick_mid_q     <= 1'b0;
      tick_bit_q     <= 1'b0;
      baud_clk_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      frac_acc_q     <= frac_acc_d;
      os_cnt_q       <= os_cnt_d;
      act_int_q      <= act_int_d;
      act_frac_q     <= act_frac_d;
      shd_int_q      <= shd_int_d;
      shd_frac_q     <= shd_frac_d;
      load_pending_q <= load_pending_d;
      tick_os_q      <= tick_os_d;
      tick_mid_q     <= tick_mid_d;
      tick_bit_q     <= tick_bit_d;
      baud_clk_q     <= baud_clk_d;
    end
  end

  assign tick_os      = tick_os_q;
  assign tick_mid     = tick_mid_q;
  assign tick_bit     = tick_bit_q;
  assign baud_clk     = baud_clk_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Testbench for uart_baud_gen_frac. Expected tick spacing comes from the
// closed form: period k after a phase restart lasts
//   max(int,2) + floor((k+1)*frac/16) - floor(k*frac/16)
// and tick k carries tick_mid when k%16==7, tick_bit when k%16==15.
module tb_uart_baud_gen_frac;
  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        sync_clear;
  logic        tick_os, tick_mid, tick_bit, baud_clk, load_pending;

  int checks = 0;
  int passed = 0;
  int cyc_n  = 0;
  int stray  = 0;
  bit dead   = 0;

  uart_baud_gen_frac dut (
    .clock(clock), .reset(reset), .enable(enable),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .sync_clear(sync_clear), .tick_os(tick_os), .tick_mid(tick_mid),
    .tick_bit(tick_bit), .baud_clk(baud_clk), .load_pending(load_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int exp_iv(input int di, input int df, input int k);
    int e;
    e = (di < 2) ? 2 : di;
    return e + ((k + 1) * df) / 16 - (k * df) / 16;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  // Advance until tick_os is seen; t = cycle stamp of that tick or -1.
  task automatic wait_os(output int t);
    int n;
    n = 0;
    t = -1;
    while (!dead && n < 200) begin
      cyc();
      n++;
      if (tick_os === 1'b1) begin
        t = cyc_n;
        break;
      end
      if (tick_mid === 1'b1 || tick_bit === 1'b1) stray++;
    end
    if (t < 0) dead = 1;
  endtask

  task automatic clear_load(input int di, input int df);
    sync_clear = 1'b1;
    div_load   = 1'b1;
    div_int    = 16'(di);
    div_frac   = 4'(df);
    cyc();
    sync_clear = 1'b0;
    div_load   = 1'b0;
  endtask

  task automatic test_reset();
    int t, prev;
    reset = 1'b0; enable = 1'b1; div_int = 16'd0; div_frac = 4'd0;
    div_load = 1'b0; sync_clear = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({tick_os, tick_mid, tick_bit, baud_clk, load_pending} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {tick_os, tick_mid, tick_bit, baud_clk, load_pending});
    else passed++;
    reset = 1'b1;
    prev = cyc_n;
    for (int k = 0; k < 10; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== exp_iv(27, 2, k))
        $display("FAIL reset_interval[%0d]: got %0d want %0d", k, t - prev, exp_iv(27, 2, k));
      else passed++;
      prev = t;
    end
  endtask

  task automatic test_basic();
    int t, prev, tbit;
    bit bclk;
    clear_load(4, 0);
    checks++;
    if ({tick_os, tick_mid, tick_bit, baud_clk, load_pending} !== 5'b0)
      $display("FAIL basic_clear: got %b want 00000", {tick_os, tick_mid, tick_bit, baud_clk, load_pending});
    else passed++;
    prev = cyc_n; bclk = 0; tbit = -1;
    for (int k = 0; k < 48; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== 4) $display("FAIL basic_interval[%0d]: got %0d want 4", k, t - prev);
      else passed++;
      if ((k % 16) == 15) bclk = ~bclk;
      checks++;
      if ({tick_mid, tick_bit, baud_clk} !== {(k % 16) == 7, (k % 16) == 15, bclk})
        $display("FAIL basic_flags[%0d]: got %b want %b", k, {tick_mid, tick_bit, baud_clk},
                 {(k % 16) == 7, (k % 16) == 15, bclk});
      else passed++;
      if (tick_bit === 1'b1) begin
        if (tbit >= 0) begin
          checks++;
          if (t - tbit !== 64) $display("FAIL basic_bit_period: got %0d want 64", t - tbit);
          else passed++;
        end
        tbit = t;
      end
      if (tick_mid === 1'b1 && tbit >= 0) begin
        checks++;
        if (t - tbit !== 32) $display("FAIL basic_mid_offset: got %0d want 32", t - tbit);
        else passed++;
      end
      prev = t;
    end
  endtask

  task automatic test_frac();
    int t, prev, t0;
    clear_load(4, 8);
    t0 = cyc_n; prev = t0;
    for (int k = 0; k < 16; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== exp_iv(4, 8, k))
        $display("FAIL frac_interval[%0d]: got %0d want %0d", k, t - prev, exp_iv(4, 8, k));
      else passed++;
      prev = t;
    end
    checks++;
    if (prev - t0 !== 72) $display("FAIL frac_total: got %0d want 72", prev - t0);
    else passed++;
  endtask

  task automatic test_clamp();
    int t, prev;
    for (int di = 0; di < 2; di++) begin
      clear_load(di, 0);
      prev = cyc_n;
      for (int k = 0; k < 20; k++) begin
        wait_os(t);
        checks++;
        if (t - prev !== 2) $display("FAIL clamp%0d_interval[%0d]: got %0d want 2", di, k, t - prev);
        else passed++;
        prev = t;
      end
    end
  endtask

  task automatic test_load();
    int t, prev;
    clear_load(4, 0);
    prev = cyc_n;
    for (int k = 0; k < 3; k++) begin wait_os(t); prev = t; end
    cyc();
    div_load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
    cyc();
    div_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1) $display("FAIL load_pending_set: got %b want 1", load_pending);
    else passed++;
    for (int k = 3; k < 16; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== 4) $display("FAIL load_old_interval[%0d]: got %0d want 4", k, t - prev);
      else passed++;
      checks++;
      if ({tick_bit, load_pending} !== {k == 15, k != 15})
        $display("FAIL load_pending_track[%0d]: got %b want %b", k, {tick_bit, load_pending}, {k == 15, k != 15});
      else passed++;
      prev = t;
    end
    for (int k = 0; k < 4; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== 10) $display("FAIL load_new_interval[%0d]: got %0d want 10", k, t - prev);
      else passed++;
      prev = t;
    end
    // Two loads before the next boundary: only the second survives.
    cyc();
    div_load = 1'b1; div_int = 16'd6;
    cyc();
    div_load = 1'b0;
    cyc(); cyc();
    div_load = 1'b1; div_int = 16'd8;
    cyc();
    div_load = 1'b0;
    for (int k = 4; k < 16; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== 10) $display("FAIL load2_old_interval[%0d]: got %0d want 10", k, t - prev);
      else passed++;
      prev = t;
    end
    for (int k = 0; k < 3; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== 8) $display("FAIL load2_new_interval[%0d]: got %0d want 8", k, t - prev);
      else passed++;
      prev = t;
    end
  endtask

  task automatic test_sync_clear();
    int t, prev;
    clear_load(4, 0);
    for (int k = 0; k < 23; k++) wait_os(t);
    checks++;
    if (baud_clk !== 1'b1) $display("FAIL sync_pre_baud: got %b want 1", baud_clk);
    else passed++;
    // Clear lands on the edge that would otherwise end a period.
    repeat (3) cyc();
    sync_clear = 1'b1;
    cyc();
    sync_clear = 1'b0;
    checks++;
    if ({tick_os, tick_mid, tick_bit, baud_clk} !== 4'b0)
      $display("FAIL sync_after_clear: got %b want 0000", {tick_os, tick_mid, tick_bit, baud_clk});
    else passed++;
    prev = cyc_n;
    for (int k = 0; k < 16; k++) begin
      wait_os(t);
      checks++;
      if ({t - prev, tick_mid, tick_bit} !== {32'd4, (k == 7), (k == 15)})
        $display("FAIL sync_tick[%0d]: got iv=%0d mid=%b bit=%b want iv=4 mid=%b bit=%b",
                 k, t - prev, tick_mid, tick_bit, k == 7, k == 15);
      else passed++;
      prev = t;
    end
  endtask

  task automatic test_enable();
    int t, prev, hits, t0;
    bit b0;
    clear_load(4, 8);
    prev = cyc_n;
    for (int k = 0; k < 5; k++) begin wait_os(t); prev = t; end
    cyc();
    enable = 1'b0;
    b0 = baud_clk; hits = 0;
    repeat (20) begin
      cyc();
      if (tick_os || tick_mid || tick_bit || (baud_clk !== b0)) hits++;
    end
    checks++;
    if (hits !== 0) $display("FAIL enable_frozen: got %0d active cycles want 0", hits);
    else passed++;
    enable = 1'b1;
    for (int k = 5; k < 16; k++) begin
      wait_os(t);
      checks++;
      if ((t - prev - ((k == 5) ? 20 : 0)) !== exp_iv(4, 8, k) || tick_bit !== (k == 15))
        $display("FAIL enable_resume[%0d]: got iv=%0d bit=%b want iv=%0d bit=%b", k,
                 t - prev - ((k == 5) ? 20 : 0), tick_bit, exp_iv(4, 8, k), k == 15);
      else passed++;
      prev = t;
    end
    // A load while frozen is applied without waiting for a bit boundary.
    enable = 1'b0;
    div_load = 1'b1; div_int = 16'd6; div_frac = 4'd0;
    cyc();
    div_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1) $display("FAIL enable_load_capture: got %b want 1", load_pending);
    else passed++;
    cyc();
    checks++;
    if (load_pending !== 1'b0) $display("FAIL enable_load_apply: got %b want 0", load_pending);
    else passed++;
    enable = 1'b1;
    t0 = cyc_n;
    wait_os(t);
    checks++;
    if (t - t0 !== 6) $display("FAIL enable_new_interval: got %0d want 6", t - t0);
    else passed++;
  endtask

  task automatic test_random();
    int t, prev, di, df;
    bit bclk;
    for (int it = 0; it < 6; it++) begin
      di = $urandom_range(0, 9);
      df = $urandom_range(0, 15);
      clear_load(di, df);
      prev = cyc_n; bclk = 0;
      for (int k = 0; k < 34; k++) begin
        wait_os(t);
        if ((k % 16) == 15) bclk = ~bclk;
        checks++;
        if ((t - prev) !== exp_iv(di, df, k) ||
            {tick_mid, tick_bit, baud_clk} !== {(k % 16) == 7, (k % 16) == 15, bclk})
          $display("FAIL rand[%0d/%0d,k=%0d]: got iv=%0d f=%b want iv=%0d f=%b", di, df, k,
                   t - prev, {tick_mid, tick_bit, baud_clk}, exp_iv(di, df, k),
                   {(k % 16) == 7, (k % 16) == 15, bclk});
        else passed++;
        prev = t;
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, prev;
    clear_load(4, 0);
    for (int k = 0; k < 20; k++) wait_os(t);
    cyc();
    div_load = 1'b1; div_int = 16'd9; div_frac = 4'd0;
    cyc();
    div_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", load_pending);
    else passed++;
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if ({tick_os, tick_mid, tick_bit, baud_clk, load_pending} !== 5'b0)
      $display("FAIL rstmid_immediate: got %b want 00000", {tick_os, tick_mid, tick_bit, baud_clk, load_pending});
    else passed++;
    repeat (3) cyc();
    reset = 1'b1;
    prev = cyc_n;
    for (int k = 0; k < 4; k++) begin
      wait_os(t);
      checks++;
      if (t - prev !== exp_iv(27, 2, k))
        $display("FAIL rstmid_interval[%0d]: got %0d want %0d", k, t - prev, exp_iv(27, 2, k));
      else passed++;
      prev = t;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_clamp();
    test_load();
    test_sync_clear();
    test_enable();
    test_random();
    test_reset_mid();
    checks++;
    if (stray !== 0 || dead) $display("FAIL stray_or_timeout: got stray=%0d timeout=%0d want 0 0", stray, dead);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
